// File: rtl/tick_shift_sequencer.sv
// Shift-register sequencer stepped by rising edges of a slow, asynchronous tick level.
// A run of STEPS steps is started from IDLE. Completion is flagged with a one-cycle done pulse.
module tick_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int STEPS = 8
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic [15:0]      step_count
);

  localparam logic [15:0] LAST = 16'(STEPS);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [2:0]       sync;
  logic             step_en;
  logic [WIDTH-1:0] q_step, q_nxt;
  logic [15:0]      cnt_nxt;
  logic             busy_nxt, done_nxt;

  // sync[0] is the metastability flop; sync[2] holds the previous synchronised level
  always_ff @(posedge clkin) begin
    if (rst) sync <= '0;
    else     sync <= {sync[1:0], tick_in};
  end

  assign step_en = sync[1] & ~sync[2];

  always_comb begin
    q_step = q;
    case (mode)
      2'b01:   q_step = {q[WIDTH-2:0], serial_in};
      2'b10:   q_step = {serial_in, q[WIDTH-1:1]};
      2'b11:   q_step = {q[WIDTH-2:0], q[WIDTH-1]};
      default: q_step = q;
    endcase
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    cnt_nxt   = step_count;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load) q_nxt = load_data;
        if (start) begin
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (step_en) begin
          q_nxt   = q_step;
          cnt_nxt = step_count + 16'd1;
          if (cnt_nxt == LAST) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state      <= IDLE;
      q          <= '0;
      step_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      q          <= q_nxt;
      step_count <= cnt_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  assign serial_out = mode[0] ? q[WIDTH-1] : q[0];

endmodule

// File: tb/tb_tick_shift_sequencer.sv
// Bench for tick_shift_sequencer (WIDTH=8, STEPS=4): table-driven runs, hand-written corner
// sequences, then random stimulus checked every cycle against an edge-indexed reference model.
module tb_tick_shift_sequencer;
  localparam int WIDTH = 8;
  localparam int STEPS = 4;
  localparam int HSZ   = 16384;

  logic             clkin = 1'b0;
  logic             rst = 1'b1;
  logic             tick_in = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             start = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             serial_in = 1'b0;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             busy;
  logic             done;
  logic [15:0]      step_count;

  tick_shift_sequencer #(.WIDTH(WIDTH), .STEPS(STEPS)) dut (
    .clkin(clkin), .rst(rst), .tick_in(tick_in), .load(load), .load_data(load_data),
    .start(start), .mode(mode), .serial_in(serial_in), .q(q), .serial_out(serial_out),
    .busy(busy), .done(done), .step_count(step_count)
  );

  always #5 clkin = ~clkin;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the tick level sampled at each edge is recorded by edge number.
  // A step is due at edge n when the sample two edges earlier was a 0->1 rise and no
  // reset hit the edge in between (reset edges record a 0 sample).
  bit samp  [HSZ];
  bit rstat [HSZ];
  int ecnt = 0;
  int mq = 0, mcnt = 0, mst = 0;
  bit mbusy = 1'b0, mdone = 1'b0;

  always @(posedge clkin) begin
    automatic bit stp = (ecnt >= 3) && samp[ecnt-2] && !samp[ecnt-3] && !rstat[ecnt-1];
    automatic int nq = mq, nc = mcnt, ns = mst;
    automatic bit nb = mbusy, nd = 1'b0;
    if (rst) begin
      nq = 0; nc = 0; ns = 0; nb = 1'b0;
    end else begin
      case (mst)
        0: begin
          if (load) nq = int'(load_data);
          if (start) begin nc = 0; nb = 1'b1; ns = 1; end
        end
        1: if (stp) begin
          case (mode)
            2'b01:   nq = (mq * 2 + int'(serial_in)) % 256;
            2'b10:   nq = mq / 2 + int'(serial_in) * 128;
            2'b11:   nq = (mq * 2) % 256 + mq / 128;
            default: nq = mq;
          endcase
          nc = mcnt + 1;
          if (nc == STEPS) begin ns = 2; nb = 1'b0; nd = 1'b1; end
        end
        default: ns = 0;
      endcase
    end
    samp[ecnt]  <= rst ? 1'b0 : tick_in;
    rstat[ecnt] <= rst;
    ecnt  <= ecnt + 1;
    mq    <= nq;
    mcnt  <= nc;
    mst   <= ns;
    mbusy <= nb;
    mdone <= nd;
  end

  always @(negedge clkin) begin
    if (done === 1'b1) done_cnt++;
    if (chk_en) begin
      chk("model_q", 32'(q), mq);
      chk("model_busy", 32'(busy), 32'(mbusy));
      chk("model_done", 32'(done), 32'(mdone));
      chk("model_step_count", 32'(step_count), mcnt);
      chk("model_serial_out", 32'(serial_out), mode[0] ? (mq / 128) % 2 : mq % 2);
    end
  end

  task automatic cyc();
    @(posedge clkin);
    #2;
  endtask

  task automatic tick_pulse();
    tick_in = 1'b1;
    repeat (5) cyc();
    tick_in = 1'b0;
    repeat (5) cyc();
  endtask

  task automatic begin_run(input logic [7:0] d, input logic [1:0] m, input logic s);
    load = 1'b1; load_data = d; start = 1'b1; mode = m; serial_in = s;
    cyc();
    load = 1'b0; start = 1'b0;
  endtask

  typedef struct {
    logic [7:0]      data;
    logic [1:0]      m;
    logic            s;
    logic [3:0][7:0] exp_q;  // exp_q[i] = q after tick i+1
  } vec_t;

  vec_t vecs [5];

  initial begin
    int d0;
    logic [7:0] qv;
    vecs[0] = '{8'hA5, 2'b01, 1'b0, {8'h50, 8'h28, 8'h94, 8'h4A}};
    vecs[1] = '{8'h81, 2'b11, 1'b0, {8'h18, 8'h0C, 8'h06, 8'h03}};
    vecs[2] = '{8'h00, 2'b10, 1'b1, {8'hF0, 8'hE0, 8'hC0, 8'h80}};
    vecs[3] = '{8'h3C, 2'b00, 1'b1, {8'h3C, 8'h3C, 8'h3C, 8'h3C}};
    vecs[4] = '{8'h0F, 2'b01, 1'b1, {8'hFF, 8'h7F, 8'h3F, 8'h1F}};

    // reset held two cycles with tick_in toggling
    tick_in = 1'b1;
    cyc();
    chk_en = 1'b1;
    tick_in = 1'b0;
    cyc();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_step_count", 32'(step_count), 32'h0);
    tick_in = 1'b1;
    rst = 1'b0;
    repeat (6) cyc();
    tick_in = 1'b0;
    repeat (4) cyc();
    chk("post_rst_q", 32'(q), 32'h0);
    chk("post_rst_done_cnt", 32'(done_cnt), 32'h0);

    // table-driven runs, each followed by one extra tick that must not move q
    foreach (vecs[v]) begin
      d0 = done_cnt;
      begin_run(vecs[v].data, vecs[v].m, vecs[v].s);
      chk("run_load_q", 32'(q), 32'(vecs[v].data));
      chk("run_busy", 32'(busy), 32'h1);
      for (int t = 0; t < 4; t++) begin
        tick_pulse();
        qv = vecs[v].exp_q[t];
        chk("tbl_q", 32'(q), 32'(qv));
        chk("tbl_step_count", 32'(step_count), 32'(t + 1));
        chk("tbl_serial_out", 32'(serial_out), 32'(vecs[v].m[0] ? qv[7] : qv[0]));
      end
      chk("tbl_done_pulses", 32'(done_cnt - d0), 32'h1);
      chk("tbl_busy_after", 32'(busy), 32'h0);
      tick_pulse();
      chk("tbl_extra_tick_q", 32'(q), 32'(vecs[v].exp_q[3]));
      chk("tbl_extra_tick_cnt", 32'(step_count), 32'h4);
    end

    // level held high: exactly one step, on the third edge after the rise is sampled
    begin_run(8'h01, 2'b01, 1'b0);
    tick_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("level_q", 32'(q), (i < 2) ? 32'h01 : 32'h02);
    end
    tick_in = 1'b0;
    repeat (5) cyc();
    for (int t = 0; t < 3; t++) tick_pulse();
    chk("level_final_q", 32'(q), 32'h10);
    chk("level_final_cnt", 32'(step_count), 32'h4);

    // load/start mid-run are ignored
    d0 = done_cnt;
    begin_run(8'h81, 2'b11, 1'b0);
    tick_pulse();
    tick_pulse();
    load = 1'b1; load_data = 8'hFF; start = 1'b1;
    cyc();
    load = 1'b0; start = 1'b0;
    chk("abuse_q", 32'(q), 32'h06);
    chk("abuse_cnt", 32'(step_count), 32'h2);
    tick_pulse();
    tick_pulse();
    chk("abuse_final_q", 32'(q), 32'h18);
    chk("abuse_done_pulses", 32'(done_cnt - d0), 32'h1);

    // reset mid-run: no done pulse, later ticks do not shift
    d0 = done_cnt;
    begin_run(8'h81, 2'b11, 1'b0);
    tick_pulse();
    tick_pulse();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_q", 32'(q), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_cnt", 32'(step_count), 32'h0);
    tick_pulse();
    tick_pulse();
    chk("midrst_later_q", 32'(q), 32'h0);
    chk("midrst_later_busy", 32'(busy), 32'h0);
    chk("midrst_done_pulses", 32'(done_cnt - d0), 32'h0);

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom % 200) == 0;
      load      = ($urandom % 8) == 0;
      start     = ($urandom % 10) == 0;
      load_data = 8'($urandom);
      serial_in = 1'($urandom);
      if (($urandom % 16) == 0) mode = 2'($urandom);
      if (($urandom % 4) == 0) tick_in = ~tick_in;
      cyc();
    end
    rst = 1'b0; load = 1'b0; start = 1'b0;
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
